// File: rtl/debug_console_pkg.sv
// Shared types and constants for the debug console: FSM encodings, the
// status register layout and the AXI response code.
package debug_console_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HIT_W,
    WR_HIT_B,
    WR_FWD
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FWD,
    RD_LOCAL
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY      = 2'b00;

  // Status word: drop counter in the upper half, FIFO level in the lower half.
  localparam int         STAT_LEVEL_LSB = 0;
  localparam int         STAT_LEVEL_W   = 16;
  localparam int         STAT_DROP_LSB  = 16;
  localparam int         STAT_DROP_W    = 16;

endpackage

// File: rtl/debug_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data shows the head entry
// whenever the FIFO is non-empty.
module debug_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  // One extra pointer bit distinguishes full from empty.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PW-1:0]];
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (PW+1)'(DEPTH));
  assign empty    = (level == '0);

endmodule

// File: rtl/debug_console.sv
// AXI-lite write snooper: captures character writes to per-channel console
// addresses into a FIFO, releases them one pulse at a time, forwards all else.
module debug_console
  import debug_console_pkg::*;
#(
  parameter int          ACTIVE       = 0,
  parameter int          NUM_CH       = 4,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR  = ADDR_BASE + 32'(4*NUM_CH),
  parameter int          FIFO_DEPTH   = 16,
  parameter int          DROP_ON_FULL = 0,
  parameter int          ASCII_WIDTH  = 8,
  localparam int         CHW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   res_n,
  input  logic                   busy,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_awaddr,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  output logic [1:0]             s_bresp,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  input  logic [31:0]            s_araddr,
  output logic                   s_rvalid,
  input  logic                   s_rready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [31:0]            m_awaddr,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic [31:0]            m_wdata,
  output logic [3:0]             m_wstrb,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [31:0]            m_araddr,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [31:0]            m_rdata,
  input  logic [1:0]             m_rresp,
  output logic                   sig,
  output logic [ASCII_WIDTH-1:0] ascii,
  output logic [CHW-1:0]         chan
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = CHW + ASCII_WIDTH;

  wr_state_t                 wr_state, wr_next;
  rd_state_t                 rd_state, rd_next;
  logic [CHW-1:0]            hit_chan;
  logic                      aw_done, w_done;
  logic [STAT_DROP_W-1:0]    drop_cnt;
  logic [31:0]               status_q;
  logic [31:0]               aw_off;
  logic                      aw_hit, ar_local;
  logic                      w_hs, w_room, push, drop, pop;
  logic [EW-1:0]             pop_data;
  logic                      fifo_full, fifo_empty;
  logic [LW-1:0]             fifo_level;

  assign m_awaddr = s_awaddr;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;
  assign m_araddr = s_araddr;

  // Subtraction wraps addresses below the base out of range as well.
  assign aw_off   = s_awaddr - ADDR_BASE;
  assign aw_hit   = (ACTIVE != 0) && (aw_off < 32'(4*NUM_CH));
  assign ar_local = (ACTIVE != 0) && (s_araddr == STATUS_ADDR);

  assign w_room = (DROP_ON_FULL != 0) || !fifo_full || pop;
  assign push   = w_hs && (!fifo_full || pop);
  assign drop   = w_hs && fifo_full && !pop;
  assign pop    = !fifo_empty && !busy && !sig;

  always_comb begin
    wr_next   = wr_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    w_hs      = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (s_awvalid) begin
          if (aw_hit) begin
            s_awready = 1'b1;
            wr_next   = WR_HIT_W;
          end else begin
            wr_next   = WR_FWD;
          end
        end
      end
      WR_HIT_W: begin
        s_wready = w_room;
        if (s_wvalid && w_room) begin
          w_hs    = 1'b1;
          wr_next = WR_HIT_B;
        end
      end
      WR_HIT_B: begin
        s_bvalid = 1'b1;
        if (s_bready) wr_next = WR_IDLE;
      end
      WR_FWD: begin
        // done flags stop a second AW/W leaking through before B returns
        m_awvalid = s_awvalid && !aw_done;
        s_awready = m_awready && !aw_done;
        m_wvalid  = s_wvalid && !w_done;
        s_wready  = m_wready && !w_done;
        s_bvalid  = m_bvalid;
        s_bresp   = m_bresp;
        m_bready  = s_bready;
        if (m_bvalid && s_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next   = rd_state;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = m_rdata;
    s_rresp   = m_rresp;
    case (rd_state)
      RD_IDLE: begin
        if (s_arvalid && ar_local) begin
          s_arready = 1'b1;
          rd_next   = RD_LOCAL;
        end else begin
          m_arvalid = s_arvalid;
          s_arready = m_arready;
          if (s_arvalid && m_arready) rd_next = RD_FWD;
        end
      end
      RD_FWD: begin
        s_rvalid = m_rvalid;
        m_rready = s_rready;
        if (m_rvalid && s_rready) rd_next = RD_IDLE;
      end
      RD_LOCAL: begin
        s_rvalid = 1'b1;
        s_rdata  = status_q;
        s_rresp  = RESP_OKAY;
        if (s_rready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      hit_chan <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      drop_cnt <= '0;
      status_q <= '0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      if (wr_state == WR_IDLE && s_awvalid && aw_hit) hit_chan <= aw_off[CHW+1:2];
      if (wr_state == WR_FWD) begin
        if (wr_next == WR_IDLE) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end else begin
          if (m_awvalid && m_awready) aw_done <= 1'b1;
          if (m_wvalid && m_wready)   w_done  <= 1'b1;
        end
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (rd_state == RD_IDLE && s_arvalid && ar_local)
        status_q <= {drop_cnt, STAT_LEVEL_W'(fifo_level)};
    end
  end

  debug_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .push_data ({hit_chan, s_wdata[ASCII_WIDTH-1:0]}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Output stage: sig is the registered pop, so it can never be high twice in a row.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sig   <= 1'b0;
      ascii <= '0;
      chan  <= '0;
    end else begin
      sig <= pop;
      if (pop) begin
        ascii <= pop_data[ASCII_WIDTH-1:0];
        chan  <= pop_data[EW-1:ASCII_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_debug_console.sv
// Scoreboard bench for debug_console: three instances (stall mode, drop mode,
// pass-through) each with a small AXI-lite responder on the interconnect side.
module tb_debug_console;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   passes = 0;

  logic        busy      [N];
  logic        s_awvalid [N], s_awready [N], s_wvalid [N], s_wready [N];
  logic        s_bvalid  [N], s_bready  [N], s_arvalid[N], s_arready[N];
  logic        s_rvalid  [N], s_rready  [N];
  logic [31:0] s_awaddr  [N], s_wdata   [N], s_araddr [N], s_rdata  [N];
  logic [3:0]  s_wstrb   [N];
  logic [1:0]  s_bresp   [N], s_rresp   [N];
  logic        m_awvalid [N], m_awready [N], m_wvalid [N], m_wready [N];
  logic        m_bvalid  [N], m_bready  [N], m_arvalid[N], m_arready[N];
  logic        m_rvalid  [N], m_rready  [N];
  logic [31:0] m_awaddr  [N], m_wdata   [N], m_araddr [N], m_rdata  [N];
  logic [3:0]  m_wstrb   [N];
  logic [1:0]  m_bresp   [N], m_rresp   [N];
  logic        sig       [N];
  logic [7:0]  ascii     [N];
  logic [1:0]  chan      [N];

  logic [9:0]  exp_chr [N][$];
  logic [31:0] exp_aw  [N][$];
  logic [31:0] exp_w   [N][$];
  logic [31:0] exp_ar  [N][$];
  int          sig_log [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    debug_console #(
      .ACTIVE       ((g == 2) ? 0 : 1),
      .NUM_CH       (4),
      .ADDR_BASE    (32'h0000_0000),
      .FIFO_DEPTH   (4),
      .DROP_ON_FULL ((g == 1) ? 1 : 0),
      .ASCII_WIDTH  (8)
    ) dut (
      .clk(clk), .res_n(res_n), .busy(busy[g]),
      .s_awvalid(s_awvalid[g]), .s_awready(s_awready[g]), .s_awaddr(s_awaddr[g]),
      .s_wvalid(s_wvalid[g]), .s_wready(s_wready[g]), .s_wdata(s_wdata[g]), .s_wstrb(s_wstrb[g]),
      .s_bvalid(s_bvalid[g]), .s_bready(s_bready[g]), .s_bresp(s_bresp[g]),
      .s_arvalid(s_arvalid[g]), .s_arready(s_arready[g]), .s_araddr(s_araddr[g]),
      .s_rvalid(s_rvalid[g]), .s_rready(s_rready[g]), .s_rdata(s_rdata[g]), .s_rresp(s_rresp[g]),
      .m_awvalid(m_awvalid[g]), .m_awready(m_awready[g]), .m_awaddr(m_awaddr[g]),
      .m_wvalid(m_wvalid[g]), .m_wready(m_wready[g]), .m_wdata(m_wdata[g]), .m_wstrb(m_wstrb[g]),
      .m_bvalid(m_bvalid[g]), .m_bready(m_bready[g]), .m_bresp(m_bresp[g]),
      .m_arvalid(m_arvalid[g]), .m_arready(m_arready[g]), .m_araddr(m_araddr[g]),
      .m_rvalid(m_rvalid[g]), .m_rready(m_rready[g]), .m_rdata(m_rdata[g]), .m_rresp(m_rresp[g]),
      .sig(sig[g]), .ascii(ascii[g]), .chan(chan[g])
    );

    assign m_awready[g] = 1'b1;
    assign m_wready[g]  = 1'b1;
    assign m_arready[g] = 1'b1;
    assign m_bresp[g]   = 2'b00;
    assign m_rresp[g]   = 2'b00;

    logic aw_seen, w_seen;
    // Interconnect responder: B after both AW and W, R one cycle after AR.
    always @(posedge clk or negedge res_n) begin
      if (!res_n) begin
        aw_seen     <= 1'b0;
        w_seen      <= 1'b0;
        m_bvalid[g] <= 1'b0;
        m_rvalid[g] <= 1'b0;
        m_rdata[g]  <= '0;
      end else begin
        if (m_bvalid[g] && m_bready[g]) m_bvalid[g] <= 1'b0;
        if (aw_seen && w_seen) begin
          m_bvalid[g] <= 1'b1;
          aw_seen     <= 1'b0;
          w_seen      <= 1'b0;
        end else begin
          if (m_awvalid[g] && m_awready[g]) aw_seen <= 1'b1;
          if (m_wvalid[g] && m_wready[g])   w_seen  <= 1'b1;
        end
        if (m_rvalid[g] && m_rready[g]) m_rvalid[g] <= 1'b0;
        if (m_arvalid[g] && m_arready[g]) begin
          m_rvalid[g] <= 1'b1;
          m_rdata[g]  <= m_araddr[g] ^ 32'hDEAD_0000;
        end
      end
    end

    logic [9:0]  e_chr;
    logic [31:0] e_w;
    always @(negedge clk) begin
      if (res_n) begin
        if (sig[g]) begin
          sig_log[g].push_back(cyc);
          if (exp_chr[g].size() == 0) chk(1'b0, "sig_unexpected", {22'd0, chan[g], ascii[g]}, 32'd0);
          else begin
            e_chr = exp_chr[g].pop_front();
            chk({chan[g], ascii[g]} == e_chr, "char", {22'd0, chan[g], ascii[g]}, {22'd0, e_chr});
          end
        end
        if (m_awvalid[g] && m_awready[g]) begin
          if (exp_aw[g].size() == 0) chk(1'b0, "m_aw_unexpected", m_awaddr[g], 32'd0);
          else begin
            e_w = exp_aw[g].pop_front();
            chk(m_awaddr[g] == e_w, "m_awaddr", m_awaddr[g], e_w);
          end
        end
        if (m_wvalid[g] && m_wready[g]) begin
          if (exp_w[g].size() == 0) chk(1'b0, "m_w_unexpected", m_wdata[g], 32'd0);
          else begin
            e_w = exp_w[g].pop_front();
            chk(m_wdata[g] == e_w, "m_wdata", m_wdata[g], e_w);
          end
        end
        if (m_arvalid[g] && m_arready[g]) begin
          if (exp_ar[g].size() == 0) chk(1'b0, "m_ar_unexpected", m_araddr[g], 32'd0);
          else begin
            e_w = exp_ar[g].pop_front();
            chk(m_araddr[g] == e_w, "m_araddr", m_araddr[g], e_w);
          end
        end
      end
    end
  end

  task automatic do_aw(input int i, input logic [31:0] a);
    bit ok = 1'b0;
    s_awaddr[i] = a; s_awvalid[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_awready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) chk(1'b0, "aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_awvalid[i] = 1'b0;
  endtask

  task automatic do_w(input int i, input logic [31:0] d, output int c);
    bit ok = 1'b0;
    c = -1;
    s_wdata[i] = d; s_wvalid[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_wready[i]) begin ok = 1'b1; c = cyc; break; end
    end
    if (!ok) chk(1'b0, "w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_wvalid[i] = 1'b0;
  endtask

  task automatic do_b(input int i, output logic [1:0] r, output int c);
    bit ok = 1'b0;
    r = 2'b11; c = -1;
    s_bready[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_bvalid[i]) begin ok = 1'b1; r = s_bresp[i]; c = cyc; break; end
    end
    if (!ok) chk(1'b0, "b_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_bready[i] = 1'b0;
  endtask

  task automatic wr_full(input int i, input logic [31:0] a, input logic [31:0] d);
    int wc, bc;
    logic [1:0] r;
    do_aw(i, a);
    do_w(i, d, wc);
    do_b(i, r, bc);
    chk(r == 2'b00, "bresp", {30'd0, r}, 32'd0);
  endtask

  task automatic do_rd(input int i, input logic [31:0] a, output logic [31:0] d,
                       output logic [1:0] r, output int ac, output int rc);
    bit ok = 1'b0;
    d = '0; r = 2'b11; ac = -1; rc = -1;
    s_araddr[i] = a; s_arvalid[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_arready[i]) begin ok = 1'b1; ac = cyc; break; end
    end
    if (!ok) chk(1'b0, "ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_arvalid[i] = 1'b0; s_rready[i] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_rvalid[i]) begin ok = 1'b1; d = s_rdata[i]; r = s_rresp[i]; rc = cyc; break; end
    end
    if (!ok) chk(1'b0, "r_timeout", 32'd0, 32'd1);
    @(posedge clk); #1 s_rready[i] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d cycles, required completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int wc, bc, ac, rc;
    logic [1:0]  r;
    logic [31:0] d;
    logic [1:0]  chs [5];
    chs[0] = 2'd0; chs[1] = 2'd1; chs[2] = 2'd3; chs[3] = 2'd2; chs[4] = 2'd1;
    for (int i = 0; i < N; i++) begin
      busy[i] = 1'b0;
      s_awvalid[i] = 1'b0; s_awaddr[i] = '0;
      s_wvalid[i] = 1'b0;  s_wdata[i] = '0; s_wstrb[i] = 4'hF;
      s_bready[i] = 1'b0;
      s_arvalid[i] = 1'b0; s_araddr[i] = '0;
      s_rready[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      chk({sig[i], ascii[i], chan[i], s_bvalid[i], s_rvalid[i], s_awready[i], s_wready[i]} == '0,
          "reset_outputs", {17'd0, sig[i], ascii[i], chan[i], s_bvalid[i], s_rvalid[i], s_awready[i], s_wready[i]}, 32'd0);
    @(posedge clk); #1 res_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single captured character: latency of B and sig relative to the W handshake
    exp_chr[0].push_back({2'd2, 8'h41});
    do_aw(0, 32'h8);
    do_w(0, 32'h41, wc);
    do_b(0, r, bc);
    chk(r == 2'b00, "t1_bresp", {30'd0, r}, 32'd0);
    chk(bc == wc + 1, "t1_b_latency", bc - wc, 32'd1);
    repeat (4) @(negedge clk);
    chk(sig_log[0].size() == 1, "t1_sig_count", sig_log[0].size(), 32'd1);
    if (sig_log[0].size() > 0) chk(sig_log[0][0] == wc + 2, "t1_sig_latency", sig_log[0][0] - wc, 32'd2);
    sig_log[0].delete();
    @(posedge clk); #1;

    // Non-hit write and read are forwarded unchanged
    exp_aw[0].push_back(32'h1000);
    exp_w[0].push_back(32'hCAFE_0042);
    wr_full(0, 32'h1000, 32'hCAFE_0042);
    exp_ar[0].push_back(32'h1000);
    do_rd(0, 32'h1000, d, r, ac, rc);
    chk(d == 32'hDEAD_1000, "t2_fwd_rdata", d, 32'hDEAD_1000);
    chk(r == 2'b00, "t2_fwd_rresp", {30'd0, r}, 32'd0);

    // Stall mode: fifth write waits until busy drops
    busy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_chr[0].push_back({chs[k], 8'h61 + 8'(k)});
      wr_full(0, 32'(4 * chs[k]), 32'hFFFF_FF00 | 32'(8'h61 + k));
    end
    exp_chr[0].push_back({chs[4], 8'h65});
    do_aw(0, 32'(4 * chs[4]));
    fork
      do_w(0, 32'h0000_0065, wc);
      begin
        repeat (5) @(negedge clk);
        chk(s_wready[0] == 1'b0, "t3_w_stalled", {31'd0, s_wready[0]}, 32'd0);
        @(posedge clk); #1 busy[0] = 1'b0;
      end
    join
    do_b(0, r, bc);
    chk(r == 2'b00, "t3_bresp5", {30'd0, r}, 32'd0);
    repeat (15) @(negedge clk);
    chk(sig_log[0].size() == 5, "t3_sig_count", sig_log[0].size(), 32'd5);
    for (int k = 1; k < sig_log[0].size(); k++)
      chk(sig_log[0][k] - sig_log[0][k-1] == 2, "t3_sig_spacing", sig_log[0][k] - sig_log[0][k-1], 32'd2);
    sig_log[0].delete();
    @(posedge clk); #1;

    // Drop mode: fifth character discarded and counted
    busy[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_chr[1].push_back({chs[k], 8'h30 + 8'(k)});
      wr_full(1, 32'(4 * chs[k]), 32'(8'h30 + k));
    end
    do_rd(1, 32'h10, d, r, ac, rc);
    chk(d == 32'h0001_0004, "t4_status", d, 32'h0001_0004);
    chk(rc == ac + 1, "t4_status_latency", rc - ac, 32'd1);
    @(posedge clk); #1 busy[1] = 1'b0;
    repeat (12) @(negedge clk);
    @(posedge clk); #1;

    // Pass-through instance: channel and status addresses are forwarded
    exp_aw[2].push_back(32'h0);
    exp_w[2].push_back(32'h41);
    wr_full(2, 32'h0, 32'h41);
    exp_ar[2].push_back(32'h10);
    do_rd(2, 32'h10, d, r, ac, rc);
    chk(d == 32'hDEAD_0010, "t5_fwd_status", d, 32'hDEAD_0010);

    // Reset while a hit write waits for B with three entries queued
    busy[0] = 1'b1;
    wr_full(0, 32'h4, 32'h71);
    wr_full(0, 32'hC, 32'h72);
    do_aw(0, 32'h8);
    do_w(0, 32'h73, wc);
    do_rd(0, 32'h10, d, r, ac, rc);
    chk(d == 32'h0000_0003, "t6_level_before", d, 32'h3);
    @(negedge clk);
    chk(s_bvalid[0] == 1'b1, "t6_in_hit_b", {31'd0, s_bvalid[0]}, 32'd1);
    #2 res_n = 1'b0;
    #1;
    chk({sig[0], ascii[0], chan[0], s_bvalid[0]} == '0, "t6_reset_outputs",
        {20'd0, sig[0], ascii[0], chan[0], s_bvalid[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 res_n = 1'b1;
    do_rd(0, 32'h10, d, r, ac, rc);
    chk(d == 32'h0, "t6_status0_after", d, 32'h0);
    do_rd(1, 32'h10, d, r, ac, rc);
    chk(d == 32'h0, "t6_status1_after", d, 32'h0);
    busy[0] = 1'b0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < N; i++) begin
      chk(exp_chr[i].size() == 0, "chr_left", exp_chr[i].size(), 32'd0);
      chk(exp_aw[i].size() == 0,  "aw_left",  exp_aw[i].size(),  32'd0);
      chk(exp_w[i].size() == 0,   "w_left",   exp_w[i].size(),   32'd0);
      chk(exp_ar[i].size() == 0,  "ar_left",  exp_ar[i].size(),  32'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
